sram64_mem32_bridge: RTL and testbench
======================================

// Module: sram64_mem32_bridge
// PURPOSE
//  Memory-side responder for the core's 64-bit byte-enabled SRAM port (addr, wea[7:0], dina, douta).
//  Serves each 64-bit access from a 32-bit downstream memory with a valid/ready request channel and an rvalid return.
//  A read is split into two 32-bit beats, low word then high word. A write issues only the halves that have byte enables set.
//  Sits between the pipeline's data-port translator and the external/bus memory; one access outstanding at a time.
// PARAMETERS
//  ADDR_W  32  width of mem_addr; mem_addr = {req_addr[ADDR_W-1:3], half, 2'b00}
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  req_valid   in   1       core request present
//  req_ready   out  1       bridge can accept (high only in IDLE and rst low)
//  req_addr    in   64      byte address; bits [2:0] ignored (doubleword aligned)
//  req_wea     in   8       byte write enables; 8'h00 means read
//  req_dina    in   64      write data, already lane-aligned
//  resp_valid  out  1       one-cycle pulse: access complete
//  resp_douta  out  64      read data; valid with resp_valid, held until next read completes
//  mem_valid   out  1       downstream beat request
//  mem_ready   in   1       downstream accepts beat
//  mem_addr    out  ADDR_W  downstream word address
//  mem_we      out  4       downstream byte enables; 0 = read beat
//  mem_wdata   out  32      downstream write data
//  mem_rvalid  in   1       downstream read data valid (>=1 cycle after read beat accepted)
//  mem_rdata   in   32      downstream read data
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_valid, resp_valid, mem_we, mem_wdata, mem_addr, resp_douta all 0; latched request cleared.
//  Reset mid-access: access abandoned, mem_valid drops immediately, no resp_valid; late mem_rvalid ignored.
//  Accept: req_valid && req_ready -> latch addr, wea, dina; is_read = (wea==0).
//  FSM: IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, RESP.
//   IDLE   -> LO_REQ if read or wea[3:0]!=0; else HI_REQ.
//   LO_REQ : mem_valid=1, half=0, mem_we=wea[3:0], mem_wdata=dina[31:0]; on mem_ready:
//            read -> LO_WAIT; write -> HI_REQ if wea[7:4]!=0 else RESP.
//   LO_WAIT: on mem_rvalid capture rdata into low word -> HI_REQ.
//   HI_REQ : mem_valid=1, half=1, mem_we=wea[7:4], mem_wdata=dina[63:32]; on mem_ready:
//            read -> HI_WAIT; write -> RESP.
//   HI_WAIT: on mem_rvalid capture rdata into high word; load resp_douta={hi,lo} -> RESP.
//   RESP   : resp_valid=1 for exactly one cycle -> IDLE.
//  mem_addr/mem_we/mem_wdata are registered and stable while mem_valid && !mem_ready.
//  mem_valid never drops without a handshake, except on reset.
//  mem_rvalid outside *_WAIT is ignored. mem_rvalid in the same cycle as the read handshake is not legal and is ignored.
//  Writes never modify resp_douta.
//  Min latency (always-ready, rvalid +1): 1-half write resp at accept+2; 2-half write at +3; read at +5.
//  req_ready is low from accept through RESP, so back-to-back requests have a 1-cycle IDLE gap.
// TESTING
//  T1 read addr 0x1008, mem returns 0x11223344 @0x1008, 0x55667788 @0x100C -> resp_douta=0x5566778811223344, resp_valid @accept+5.
//  T2 write wea=0x0C dina=0x0000_0000_AABB_0000 addr 0x20 -> one beat: mem_addr=0x20, mem_we=0xC,
//     mem_wdata=0xAABB0000; no hi beat; resp @+2.
//  T3 write wea=0xF0 addr 0x40 -> only hi beat, mem_addr=0x44, mem_we=0xF; wea=0xFF -> lo beat then hi beat, resp @+3.
//  T4 mem_ready low 3 cycles on LO_REQ -> mem_valid/addr/we/wdata held constant, resp delayed by 3 cycles.
//  T5 assert rst during LO_WAIT, then stray mem_rvalid after rst release -> no resp_valid, state IDLE, resp_douta=0.
//  T6 spurious mem_rvalid in IDLE and req_valid held during busy -> ignored; second request accepted only after RESP.

Source files
------------

// File: rtl/sram64_mem32_bridge_if.sv
// Request/response bundle between the core's 64-bit SRAM port, the bridge,
// and the 32-bit downstream memory channel.
interface sram64_mem32_bridge_if #(
  parameter int ADDR_W = 32
);
  // core side
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic [7:0]        req_wea;
  logic [63:0]       req_dina;
  logic              resp_valid;
  logic [63:0]       resp_douta;
  // downstream memory side
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  // bridge view
  modport slave (
    input  req_valid, req_addr, req_wea, req_dina,
    output req_ready, resp_valid, resp_douta,
    output mem_valid, mem_addr, mem_we, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  // environment view: the core plus the downstream memory
  modport master (
    output req_valid, req_addr, req_wea, req_dina,
    input  req_ready, resp_valid, resp_douta,
    input  mem_valid, mem_addr, mem_we, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/sram64_mem32_bridge.sv
// Serves one 64-bit byte-enabled SRAM access at a time from a 32-bit memory.
// Reads issue two beats (low word, then high word); writes issue only the
// halves that carry byte enables. Completion is a one-cycle resp_valid pulse.
module sram64_mem32_bridge #(
  parameter int ADDR_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  sram64_mem32_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO_REQ  = 3'd1,
    LO_WAIT = 3'd2,
    HI_REQ  = 3'd3,
    HI_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t             state_reg;
  logic [ADDR_W-4:0]  addr_reg;     // doubleword index; half and byte bits are appended per beat
  logic [7:0]         wea_reg;
  logic [63:0]        dina_reg;
  logic               is_read_reg;
  logic [31:0]        lo_reg;       // low read word parked until the high word returns

  // Address bits above the memory window and the byte offset are not used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[63:ADDR_W], bus.req_addr[2:0]};

  // Requests are taken only from IDLE, and never while reset is asserted.
  assign bus.req_ready = (state_reg == IDLE) && !rst;

  // Access sequencer: all downstream and response outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wea_reg        <= '0;
      dina_reg       <= '0;
      is_read_reg    <= 1'b0;
      lo_reg         <= '0;
      bus.mem_valid  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_we     <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_douta <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            addr_reg      <= bus.req_addr[ADDR_W-1:3];
            wea_reg       <= bus.req_wea;
            dina_reg      <= bus.req_dina;
            is_read_reg   <= (bus.req_wea == 8'h00);
            bus.mem_valid <= 1'b1;
            // A write with no low-lane enables skips straight to the high beat.
            if (bus.req_wea == 8'h00 || bus.req_wea[3:0] != 4'h0) begin
              state_reg     <= LO_REQ;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:3], 1'b0, 2'b00};
              bus.mem_we    <= bus.req_wea[3:0];
              bus.mem_wdata <= bus.req_dina[31:0];
            end else begin
              state_reg     <= HI_REQ;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:3], 1'b1, 2'b00};
              bus.mem_we    <= bus.req_wea[7:4];
              bus.mem_wdata <= bus.req_dina[63:32];
            end
          end
        end
        LO_REQ: begin
          if (bus.mem_ready) begin
            if (is_read_reg) begin
              bus.mem_valid <= 1'b0;
              state_reg     <= LO_WAIT;
            end else if (wea_reg[7:4] != 4'h0) begin
              // mem_valid stays high: the high beat follows immediately.
              state_reg     <= HI_REQ;
              bus.mem_addr  <= {addr_reg, 1'b1, 2'b00};
              bus.mem_we    <= wea_reg[7:4];
              bus.mem_wdata <= dina_reg[63:32];
            end else begin
              bus.mem_valid  <= 1'b0;
              bus.resp_valid <= 1'b1;
              state_reg      <= RESP;
            end
          end
        end
        LO_WAIT: begin
          if (bus.mem_rvalid) begin
            lo_reg        <= bus.mem_rdata;
            state_reg     <= HI_REQ;
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= {addr_reg, 1'b1, 2'b00};
            bus.mem_we    <= wea_reg[7:4];
            bus.mem_wdata <= dina_reg[63:32];
          end
        end
        HI_REQ: begin
          if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
            if (is_read_reg) begin
              state_reg <= HI_WAIT;
            end else begin
              bus.resp_valid <= 1'b1;
              state_reg      <= RESP;
            end
          end
        end
        HI_WAIT: begin
          if (bus.mem_rvalid) begin
            bus.resp_douta <= {bus.mem_rdata, lo_reg};
            bus.resp_valid <= 1'b1;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          state_reg      <= IDLE;
        end
        default: begin
          bus.mem_valid  <= 1'b0;
          bus.resp_valid <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram64_mem32_bridge.sv
// Directed bench for sram64_mem32_bridge: a scripted 32-bit memory responder
// plus one task per scenario, each with hand-computed expectations.
module tb_sram64_mem32_bridge;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sram64_mem32_bridge_if #(.ADDR_W(32)) bus ();

  sram64_mem32_bridge #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } beat_t;

  beat_t beats[$];
  int    stall_left;   // cycles mem_ready is held low while mem_valid is high
  int    rv_delay;     // extra cycles before read data returns
  int    pend_cnt;
  logic [31:0] pend_data;
  logic  stray_req;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_1008: return 32'h1122_3344;
      32'h0000_100C: return 32'h5566_7788;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Downstream memory responder; everything changes on the falling edge.
  initial begin
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    pend_cnt  = 0;
    pend_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = pend_data;
        end
      end
      if (stray_req) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        stray_req      = 1'b0;
      end
      if (bus.mem_valid && stall_left > 0) begin
        bus.mem_ready = 1'b0;
        stall_left--;
      end else begin
        bus.mem_ready = 1'b1;
      end
      if (bus.mem_valid && bus.mem_ready) begin
        beats.push_back('{bus.mem_addr, bus.mem_we, bus.mem_wdata});
        if (bus.mem_we == 4'h0) begin
          pend_cnt  = 1 + rv_delay;
          pend_data = mem_model(bus.mem_addr);
        end
      end
    end
  end

  // Present one request from IDLE; returns just after the accepting edge.
  task automatic issue(input logic [63:0] a, input logic [7:0] w, input logic [63:0] d);
    @(negedge clk);
    bus.req_addr  = a;
    bus.req_wea   = w;
    bus.req_dina  = d;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Cycles from acceptance until resp_valid is seen; 0 if it never comes.
  task automatic wait_resp(input int start, output int lat);
    lat = 0;
    for (int k = start; k <= 60; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wea   = '0;
    bus.req_dina  = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.mem_valid, bus.resp_valid, bus.mem_we} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 000000", {bus.mem_valid, bus.resp_valid, bus.mem_we});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.resp_douta} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.resp_douta});
    end
    total++;
    if (bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_low: got %b expected 0", bus.req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_high: got %b expected 1", bus.req_ready);
    end
    $display("txn reset released");
  endtask

  task automatic test_read();
    int lat;
    beats.delete();
    issue(64'h1008, 8'h00, 64'h0);
    wait_resp(1, lat);
    $display("txn read addr=1008 lat=%0d data=%h", lat, bus.resp_douta);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL read_latency: got %0d expected 5", lat);
    end
    total++;
    if (bus.resp_douta !== 64'h5566_7788_1122_3344) begin
      bad++;
      $display("FAIL read_data: got %h expected 5566778811223344", bus.resp_douta);
    end
    total++;
    if (beats.size() != 2 || beats[0].addr !== 32'h1008 || beats[0].we !== 4'h0 ||
        beats[1].addr !== 32'h100C || beats[1].we !== 4'h0) begin
      bad++;
      $display("FAIL read_beats: got %0d beats first addr %h expected 2 beats 1008/100c", beats.size(),
               (beats.size() > 0) ? beats[0].addr : 32'h0);
    end
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_pulse_width: got %b expected 0", bus.resp_valid);
    end
  endtask

  task automatic test_write_partial();
    int lat;
    beats.delete();
    issue(64'h20, 8'h0C, 64'h0000_0000_AABB_0000);
    wait_resp(1, lat);
    $display("txn write addr=20 wea=0c lat=%0d beats=%0d", lat, beats.size());
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL wr_lo_latency: got %0d expected 2", lat);
    end
    total++;
    if (beats.size() != 1 || beats[0].addr !== 32'h20 || beats[0].we !== 4'hC ||
        beats[0].wdata !== 32'hAABB_0000) begin
      bad++;
      $display("FAIL wr_lo_beat: got %0d beats %h/%h/%h expected 1 beat 00000020/c/aabb0000", beats.size(),
               (beats.size() > 0) ? beats[0].addr : 32'h0, (beats.size() > 0) ? beats[0].we : 4'h0,
               (beats.size() > 0) ? beats[0].wdata : 32'h0);
    end
    beats.delete();
    issue(64'h40, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    wait_resp(1, lat);
    $display("txn write addr=40 wea=f0 lat=%0d beats=%0d", lat, beats.size());
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL wr_hi_latency: got %0d expected 2", lat);
    end
    total++;
    if (beats.size() != 1 || beats[0].addr !== 32'h44 || beats[0].we !== 4'hF ||
        beats[0].wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL wr_hi_beat: got %0d beats addr %h expected 1 beat 00000044/f/deadbeef", beats.size(),
               (beats.size() > 0) ? beats[0].addr : 32'h0);
    end
  endtask

  task automatic test_write_full();
    int lat;
    beats.delete();
    issue(64'h48, 8'hFF, 64'h0123_4567_89AB_CDEF);
    wait_resp(1, lat);
    $display("txn write addr=48 wea=ff lat=%0d beats=%0d", lat, beats.size());
    total++;
    if (lat !== 3) begin
      bad++;
      $display("FAIL wr_full_latency: got %0d expected 3", lat);
    end
    total++;
    if (beats.size() != 2 || beats[0].addr !== 32'h48 || beats[0].wdata !== 32'h89AB_CDEF ||
        beats[1].addr !== 32'h4C || beats[1].wdata !== 32'h0123_4567 || beats[1].we !== 4'hF) begin
      bad++;
      $display("FAIL wr_full_beats: got %0d beats expected 2 beats 48/89abcdef 4c/01234567", beats.size());
    end
    total++;
    if (bus.resp_douta !== 64'h5566_7788_1122_3344) begin
      bad++;
      $display("FAIL wr_keeps_douta: got %h expected 5566778811223344", bus.resp_douta);
    end
  endtask

  task automatic test_stall();
    int lat;
    int held_bad;
    held_bad = 0;
    beats.delete();
    stall_left = 3;
    issue(64'h80, 8'h0F, 64'h0000_0000_CAFE_F00D);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if ({bus.mem_valid, bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {1'b1, 32'h80, 4'hF, 32'hCAFE_F00D})
        held_bad++;
    end
    total++;
    if (held_bad !== 0) begin
      bad++;
      $display("FAIL stall_hold: got %0d unstable cycles expected 0", held_bad);
    end
    wait_resp(4, lat);
    $display("txn write addr=80 wea=0f stalled lat=%0d", lat);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL stall_latency: got %0d expected 5", lat);
    end
    total++;
    if (beats.size() != 1) begin
      bad++;
      $display("FAIL stall_beats: got %0d expected 1", beats.size());
    end
  endtask

  task automatic test_reset_mid_access();
    int seen;
    seen = 0;
    rv_delay = 3;
    issue(64'h1008, 8'h00, 64'h0);
    @(negedge clk);           // LO_REQ, handshake at the next edge
    @(negedge clk);           // LO_WAIT, data not yet returned
    rst = 1'b1;
    #1;
    total++;
    if ({bus.mem_valid, bus.req_ready} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_outputs: got %b expected 00", {bus.mem_valid, bus.req_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_valid) seen++;
    end
    rv_delay = 0;
    $display("txn reset during read wait, late rvalid delivered");
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrst_activity: got %0d active cycles expected 0", seen);
    end
    total++;
    if ({bus.req_ready, bus.resp_douta} !== {1'b1, 64'h0}) begin
      bad++;
      $display("FAIL midrst_idle: got %b/%h expected 1/0", bus.req_ready, bus.resp_douta);
    end
  endtask

  task automatic test_back_to_back();
    int first_lat;
    int second_lat;
    int ready_busy;
    int ready_gap;
    first_lat  = 0;
    second_lat = 0;
    ready_busy = 0;
    ready_gap  = 0;
    @(posedge clk);
    #1 stray_req = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.resp_douta} !== 65'h0) begin
      bad++;
      $display("FAIL stray_idle: got %b/%h expected 0/0", bus.resp_valid, bus.resp_douta);
    end
    beats.delete();
    @(negedge clk);
    bus.req_addr  = 64'h1008;
    bus.req_wea   = 8'h00;
    bus.req_dina  = 64'h0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_addr = 64'h100;
    bus.req_wea  = 8'h0F;
    bus.req_dina = 64'h0000_0000_1234_5678;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (first_lat == 0 && bus.req_ready) ready_busy++;
      if (first_lat != 0 && k == first_lat + 1) ready_gap = bus.req_ready ? 1 : 0;
      if (first_lat != 0 && k == first_lat + 2) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        if (first_lat == 0) begin
          first_lat = k;
          if (bus.req_ready) ready_busy++;
          $display("txn read addr=1008 held-valid lat=%0d data=%h", k, bus.resp_douta);
          total++;
          if (bus.resp_douta !== 64'h5566_7788_1122_3344) begin
            bad++;
            $display("FAIL b2b_read_data: got %h expected 5566778811223344", bus.resp_douta);
          end
        end else begin
          second_lat = k;
          break;
        end
      end
    end
    bus.req_valid = 1'b0;
    $display("txn write addr=100 wea=0f second resp at %0d", second_lat);
    total++;
    if ({first_lat, second_lat} !== {32'd5, 32'd8}) begin
      bad++;
      $display("FAIL b2b_timing: got %0d/%0d expected 5/8", first_lat, second_lat);
    end
    total++;
    if ({ready_busy, ready_gap} !== {32'd0, 32'd1}) begin
      bad++;
      $display("FAIL b2b_ready: got busy=%0d gap=%0d expected 0/1", ready_busy, ready_gap);
    end
    total++;
    if (beats.size() != 3 || beats[2].addr !== 32'h100 || beats[2].we !== 4'hF ||
        beats[2].wdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL b2b_beats: got %0d beats expected 3 ending 100/f/12345678", beats.size());
    end
    total++;
    if (bus.resp_douta !== 64'h5566_7788_1122_3344) begin
      bad++;
      $display("FAIL b2b_douta_kept: got %h expected 5566778811223344", bus.resp_douta);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    stall_left = 0;
    rv_delay   = 0;
    stray_req  = 1'b0;
    test_reset();
    test_read();
    test_write_partial();
    test_write_full();
    test_stall();
    test_reset_mid_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
